mult_bcd_disp: RTL

Sequential output stage downstream of the 4x4 combinational multiplier. It captures the 8-bit product on request and converts it to three BCD digits with a serial double-dabble engine. It then drives a 4-digit, active-low, multiplexed 7-segment display, with leading zeros blanked. It is the only clocked block between the multiplier and the board display pins.

---
 rtl/mult_bcd_disp_pkg.sv | 14 +
 rtl/mult_bcd_disp_if.sv | 13 +
 rtl/mult_bcd_disp_seg7_dec.sv | 29 ++
 rtl/mult_bcd_disp.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mult_bcd_disp_pkg.sv
// Shared types and constants for the multiplier BCD/display output stage.
package mult_bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam logic [3:0] ITER_COUNT = 4'd8;

endpackage

// File: rtl/mult_bcd_disp_if.sv
// Product capture / result bus between the multiplier side and the BCD stage.
interface mult_bcd_disp_if;

  logic [7:0]  prod_i;
  logic        load_i;
  logic        busy_o;
  logic        done_o;
  logic [11:0] bcd_o;

  modport master (output prod_i, output load_i, input busy_o, input done_o, input bcd_o);
  modport slave  (input prod_i, input load_i, output busy_o, output done_o, output bcd_o);

endinterface

// File: rtl/mult_bcd_disp_seg7_dec.sv
// Nibble to active-low {g..a} segment code; non-decimal nibbles and blank requests go dark.
module seg7_dec
  import mult_bcd_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_nibble)
        4'd0:    o_seg = 7'b1000000;
        4'd1:    o_seg = 7'b1111001;
        4'd2:    o_seg = 7'b0100100;
        4'd3:    o_seg = 7'b0110000;
        4'd4:    o_seg = 7'b0011001;
        4'd5:    o_seg = 7'b0010010;
        4'd6:    o_seg = 7'b0000010;
        4'd7:    o_seg = 7'b1111000;
        4'd8:    o_seg = 7'b0000000;
        4'd9:    o_seg = 7'b0010000;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/mult_bcd_disp.sv
// Captures the 8-bit product, converts it to BCD by serial double-dabble and
// scans the result onto a 4-digit active-low multiplexed display.
module mult_bcd_disp
  import mult_bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  mult_bcd_disp_if.slave    bus,
  output logic [3:0]        an_o,
  output logic [6:0]        seg_o,
  output logic              dp_o
);

  localparam int CW = $clog2(REFRESH_DIV);

  state_t          r_state;
  state_t          w_next;
  logic [19:0]     r_shift;
  logic [19:0]     w_adj;
  logic [3:0]      r_iter;
  logic [11:0]     r_bcd;
  logic [CW-1:0]   r_refresh;
  logic [1:0]      r_digit;
  logic [3:0]      w_nibble;
  logic            w_blank;
  logic [6:0]      w_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // CONV holds one extra cycle after the 8th iteration so the capture sees the final register
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.load_i) w_next = CONV;
      CONV:    if (r_iter == ITER_COUNT) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_shift;
    if (r_shift[11:8]  >= 4'd5) w_adj[11:8]  = r_shift[11:8]  + 4'd3;
    if (r_shift[15:12] >= 4'd5) w_adj[15:12] = r_shift[15:12] + 4'd3;
    if (r_shift[19:16] >= 4'd5) w_adj[19:16] = r_shift[19:16] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_iter  <= '0;
      r_bcd   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.load_i) begin
          r_shift <= {12'b0, bus.prod_i};
          r_iter  <= '0;
        end
        CONV: if (r_iter != ITER_COUNT) begin
          r_shift <= {w_adj[18:0], 1'b0};
          r_iter  <= r_iter + 4'd1;
        end else begin
          r_bcd <= r_shift[19:8];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o = (r_state != IDLE);
  assign bus.done_o = (r_state == DONE);
  assign bus.bcd_o  = r_bcd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_digit   <= '0;
    end else if (r_refresh == CW'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_digit   <= r_digit + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Leading-zero blanking: tens only dark when hundreds is also zero
  always_comb begin
    w_nibble = 4'd0;
    w_blank  = 1'b1;
    case (r_digit)
      2'd0: begin w_nibble = r_bcd[3:0];  w_blank = 1'b0; end
      2'd1: begin w_nibble = r_bcd[7:4];  w_blank = (r_bcd[11:4] == 8'd0); end
      2'd2: begin w_nibble = r_bcd[11:8]; w_blank = (r_bcd[11:8] == 4'd0); end
      default: begin w_nibble = 4'd0;     w_blank = 1'b1; end
    endcase
  end

  seg7_dec u_seg7_dec (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_o  <= AN_OFF;
      seg_o <= SEG_BLANK;
    end else begin
      an_o  <= ~(4'b0001 << r_digit);
      seg_o <= w_seg;
    end
  end

  assign dp_o = 1'b1;

endmodule
